// File: rtl/gb_bus_recorder_if.sv
`default_nettype none
// ============================================================================
// Module   : gb_bus_recorder_if
// Brief    : Game Boy cartridge-slot bus signals as seen by the recorder.
// Revision : 1.0
// ============================================================================
interface gb_bus_recorder_if;
    logic        phi;
    logic        n_rd;
    logic        n_wr;
    logic        n_cs_rom;
    logic        n_cs_xram;
    logic [14:0] adr;
    logic [7:0]  data;

    modport master (
        output phi, n_rd, n_wr, n_cs_rom, n_cs_xram, adr, data
    );

    modport slave (
        input  phi, n_rd, n_wr, n_cs_rom, n_cs_xram, adr, data
    );
endinterface
`default_nettype wire

// File: rtl/gb_bus_recorder.sv
`default_nettype none
// ============================================================================
// Module   : gb_bus_recorder
// Brief    : Captures slot read/write bus cycles as 4-byte records into the
//            recording RAM. Optional address trigger: GB_BUS_REC_TRIG_EN.
// Revision : 1.0
// ============================================================================
module gb_bus_recorder #(
    parameter int ADR_WIDTH   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    gb_bus_recorder_if.slave     bus,
`ifdef GB_BUS_REC_TRIG_EN
    input  logic [15:0]          trig_adr,
`endif
    output logic [ADR_WIDTH-1:0] wr_adr,
    output logic [7:0]           wr_data,
    output logic                 wr_en,
    output logic                 busy,
    output logic                 full,
    output logic                 lost,
    output logic [ADR_WIDTH-2:0] rec_count
);

    localparam int c_BUS_W = 28;
    localparam logic [ADR_WIDTH-2:0] c_REC_MAX = {1'b1, {(ADR_WIDTH-2){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REC   = 3'd1,
        S_WR0   = 3'd2,
        S_WR1   = 3'd3,
        S_WR2   = 3'd4,
        S_WR3   = 3'd5,
        S_DONE  = 3'd6
`ifdef GB_BUS_REC_TRIG_EN
        , S_ARMED = 3'd7
`endif
    } state_t;

`ifdef GB_BUS_REC_TRIG_EN
    localparam state_t c_START_STATE = S_ARMED;
`else
    localparam state_t c_START_STATE = S_REC;
`endif

    // Packed bus word: {phi, n_cs_xram, n_cs_rom, n_wr, n_rd, adr[14:0], data[7:0]}
    logic [c_BUS_W-1:0]                  w_raw;
    logic [SYNC_STAGES-1:0][c_BUS_W-1:0] r_sync;
    logic [c_BUS_W-1:0]                  w_sync;
    logic                                r_phi_q;
    logic [c_BUS_W-2:0]                  r_bus_q;
    logic [c_BUS_W-2:0]                  r_snap;
    logic                                r_snap_drop;
    logic                                r_drop;
    logic                                r_stop_pend;
    state_t                              r_state;

    logic                 w_event;
    logic                 w_rec_ev;
    logic                 w_trig_ok;
    logic                 w_in_wr;
    logic [1:0]           w_k_nxt;
    state_t               w_wr_next;
    logic [ADR_WIDTH-2:0] w_count_nxt;

    assign w_raw  = {bus.phi, bus.n_cs_xram, bus.n_cs_rom, bus.n_wr, bus.n_rd, bus.adr, bus.data};
    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_phi_q <= 1'b0;
            r_bus_q <= '0;
        end else begin
            r_sync[0] <= w_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_phi_q <= w_sync[27];
            // Snapshot only follows the bus while phi is high
            if (w_sync[27]) begin
                r_bus_q <= w_sync[26:0];
            end
        end
    end

    assign w_event     = r_phi_q & ~w_sync[27];
    assign w_rec_ev    = w_event & ~(r_bus_q[23] & r_bus_q[24]);
    assign w_count_nxt = rec_count + 1'b1;
    assign w_in_wr     = (r_state == S_WR0) || (r_state == S_WR1) ||
                         (r_state == S_WR2) || (r_state == S_WR3);

`ifdef GB_BUS_REC_TRIG_EN
    assign w_trig_ok = (r_state != S_ARMED) || ({r_bus_q[25], r_bus_q[22:8]} == trig_adr);
`else
    assign w_trig_ok = 1'b1;
`endif

    always_comb begin
        w_k_nxt   = 2'd1;
        w_wr_next = S_WR1;
        case (r_state)
            S_WR1:   begin w_k_nxt = 2'd2; w_wr_next = S_WR2; end
            S_WR2:   begin w_k_nxt = 2'd3; w_wr_next = S_WR3; end
            default: begin w_k_nxt = 2'd1; w_wr_next = S_WR1; end
        endcase
    end

    function automatic logic [7:0] rec_byte(input logic [26:0] s, input logic d, input logic [1:0] k);
        logic [7:0] b;
        case (k)
            2'd0:    b = s[15:8];
            2'd1:    b = {s[25], s[22:16]};
            2'd2:    b = s[7:0];
            default: b = {4'b0000, s[26], s[24], s[23], d};
        endcase
        return b;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            wr_en       <= 1'b0;
            wr_adr      <= '0;
            wr_data     <= '0;
            busy        <= 1'b0;
            full        <= 1'b0;
            lost        <= 1'b0;
            rec_count   <= '0;
            r_snap      <= '0;
            r_snap_drop <= 1'b0;
            r_drop      <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                rec_count   <= '0;
                full        <= 1'b0;
                lost        <= 1'b0;
                r_drop      <= 1'b0;
                r_stop_pend <= 1'b0;
                r_state     <= stop ? S_IDLE : c_START_STATE;
                busy        <= ~stop;
            end else begin
                // Cycles arriving while a record is being written are lost
                if (w_in_wr) begin
                    if (w_rec_ev) begin
                        r_drop <= 1'b1;
                        lost   <= 1'b1;
                    end
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                end
                case (r_state)
`ifdef GB_BUS_REC_TRIG_EN
                    S_ARMED,
`endif
                    S_REC: begin
                        if (stop) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else if (w_rec_ev && w_trig_ok) begin
                            r_snap      <= r_bus_q;
                            r_snap_drop <= r_drop;
                            r_drop      <= 1'b0;
                            r_state     <= S_WR0;
                            wr_en       <= 1'b1;
                            wr_adr      <= {rec_count[ADR_WIDTH-3:0], 2'd0};
                            wr_data     <= rec_byte(r_bus_q, r_drop, 2'd0);
                        end
                    end
                    S_WR0, S_WR1, S_WR2: begin
                        r_state <= w_wr_next;
                        wr_en   <= 1'b1;
                        wr_adr  <= {rec_count[ADR_WIDTH-3:0], w_k_nxt};
                        wr_data <= rec_byte(r_snap, r_snap_drop, w_k_nxt);
                    end
                    S_WR3: begin
                        rec_count   <= w_count_nxt;
                        r_stop_pend <= 1'b0;
                        if (w_count_nxt == c_REC_MAX) begin
                            r_state <= S_DONE;
                            full    <= 1'b1;
                            busy    <= 1'b0;
                        end else if (r_stop_pend || stop) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= S_REC;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gb_bus_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_bus_recorder
// Brief    : Directed scoreboard bench for gb_bus_recorder (ADR_WIDTH=4).
// Revision : 1.0
// ============================================================================
module tb_gb_bus_recorder;
    localparam int AW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stop  = 1'b0;
`ifdef GB_BUS_REC_TRIG_EN
    logic [15:0] trig_adr = 16'h0000;
`endif
    logic [AW-1:0] wr_adr;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          busy;
    logic          full;
    logic          lost;
    logic [AW-2:0] rec_count;

    gb_bus_recorder_if bus ();

    gb_bus_recorder #(.ADR_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .bus       (bus),
`ifdef GB_BUS_REC_TRIG_EN
        .trig_adr  (trig_adr),
`endif
        .wr_adr    (wr_adr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .busy      (busy),
        .full      (full),
        .lost      (lost),
        .rec_count (rec_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_assert = 0;
    int  n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_assert++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_write: observed adr 0x%0h data 0x%0h expected no write", wr_adr, wr_data);
            end
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_adr", 32'(wr_adr), 32'(mon_e.a));
                check("wr_data", 32'(wr_data), 32'(mon_e.d));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.n_rd      = 1'b1;
        bus.n_wr      = 1'b1;
        bus.n_cs_rom  = 1'b1;
        bus.n_cs_xram = 1'b1;
    endtask

    task automatic set_bus(input logic [14:0] a, input logic [7:0] d, input logic nrd,
                           input logic nwr, input logic ncs, input logic nxram);
        bus.adr       = a;
        bus.data      = d;
        bus.n_rd      = nrd;
        bus.n_wr      = nwr;
        bus.n_cs_rom  = ncs;
        bus.n_cs_xram = nxram;
    endtask

    task automatic push_rec(input logic [14:0] a, input logic [7:0] d, input logic nrd,
                            input logic nwr, input logic ncs, input logic nxram,
                            input logic drop, input int idx, input int nbytes);
        logic [7:0] b [4];
        wr_t        e;
        b[0] = a[7:0];
        b[1] = {ncs, a[14:8]};
        b[2] = d;
        b[3] = {4'b0000, nxram, nwr, nrd, drop};
        for (int k = 0; k < nbytes; k++) begin
            e.a = AW'(idx * 4 + k);
            e.d = b[k];
            exp_q.push_back(e);
        end
    endtask

    task automatic bus_cycle(input logic [14:0] a, input logic [7:0] d, input logic nrd,
                             input logic nwr, input logic ncs, input logic nxram);
        set_bus(a, d, nrd, nwr, ncs, nxram);
        bus.phi = 1'b1;
        tick(3);
        bus.phi = 1'b0;
        tick(10);
        idle_bus();
    endtask

    task automatic do_start(input logic [15:0] first);
`ifdef GB_BUS_REC_TRIG_EN
        trig_adr = first;
`else
        if (first == 16'hFFFF) $display("note: start");
`endif
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Waits for the first byte of a record; returns at the negedge of WR0
    task automatic wait_wr0(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_assert++;
        assert (ok) else begin
            n_fail++;
            $error("FAIL %s: observed no write within 30 clks expected a record", tag);
        end
    endtask

    initial begin
        bus.phi  = 1'b0;
        bus.adr  = '0;
        bus.data = '0;
        idle_bus();
        tick(3);
        @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_adr", 32'(wr_adr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        check("rst_rec_count", 32'(rec_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(2);

`ifdef GB_BUS_REC_TRIG_EN
        do_start(16'h0100);
        @(negedge clk);
        check("armed_busy", 32'(busy), 32'd1);
        tick(1);
        bus_cycle(15'h00FF, 8'h12, 1'b0, 1'b1, 1'b0, 1'b1);
        check("armed_no_rec", 32'(rec_count), 32'd0);
        push_rec(15'h0100, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 4);
        bus_cycle(15'h0100, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1);
        check("trig_rec_count", 32'(rec_count), 32'd1);
`endif

        do_start(16'h0150);
        @(negedge clk);
        check("start_busy", 32'(busy), 32'd1);
        check("start_rec_count", 32'(rec_count), 32'd0);
        tick(1);
        push_rec(15'h0150, 8'h3E, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 4);
        bus_cycle(15'h0150, 8'h3E, 1'b0, 1'b1, 1'b0, 1'b1);
        check("read_rec_count", 32'(rec_count), 32'd1);

        push_rec(15'h2000, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 4);
        bus_cycle(15'h2000, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1);
        check("write_rec_count", 32'(rec_count), 32'd2);

        bus_cycle(15'h0300, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
        check("idle_rec_count", 32'(rec_count), 32'd2);
        check("idle_lost", 32'(lost), 32'd0);

        // Two falling phi edges 3 clks apart: the second lands mid-record
        push_rec(15'h1234, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 4);
        set_bus(15'h1234, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        bus.phi = 1'b1;
        tick(3);
        bus.phi = 1'b0;
        tick(1);
        bus.phi = 1'b1;
        tick(2);
        bus.phi = 1'b0;
        tick(10);
        idle_bus();
        check("drop_lost", 32'(lost), 32'd1);
        check("drop_rec_count", 32'(rec_count), 32'd3);

        push_rec(15'h2ABC, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3, 4);
        bus_cycle(15'h2ABC, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b0);
        check("full_rec_count", 32'(rec_count), 32'd4);
        check("full_flag", 32'(full), 32'd1);
        check("full_busy", 32'(busy), 32'd0);
        check("full_lost_sticky", 32'(lost), 32'd1);

        bus_cycle(15'h0444, 8'h44, 1'b0, 1'b1, 1'b0, 1'b1);
        check("done_rec_count", 32'(rec_count), 32'd4);
        check("done_full", 32'(full), 32'd1);

        // Stop during the second byte of a record
        do_start(16'h0042);
        @(negedge clk);
        check("restart_full", 32'(full), 32'd0);
        check("restart_lost", 32'(lost), 32'd0);
        check("restart_rec_count", 32'(rec_count), 32'd0);
        tick(1);
        push_rec(15'h0042, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 4);
        set_bus(15'h0042, 8'h99, 1'b0, 1'b1, 1'b0, 1'b1);
        bus.phi = 1'b1;
        tick(3);
        bus.phi = 1'b0;
        wait_wr0("stop_wait");
        @(posedge clk); #1;
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        idle_bus();
        tick(5);
        @(negedge clk);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_rec_count", 32'(rec_count), 32'd1);
        tick(1);
        bus_cycle(15'h0555, 8'h55, 1'b0, 1'b1, 1'b0, 1'b1);
        check("stop_idle_rec_count", 32'(rec_count), 32'd1);

        // Reset during the second byte of a record
        do_start(16'h0043);
        push_rec(15'h0043, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2);
        set_bus(15'h0043, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);
        bus.phi = 1'b1;
        tick(3);
        bus.phi = 1'b0;
        wait_wr0("reset_wait");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_wr_en", 32'(wr_en), 32'd0);
        check("reset_mid_busy", 32'(busy), 32'd0);
        check("reset_mid_rec_count", 32'(rec_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle_bus();
        tick(5);

        // start and stop together: counters clear, recorder stays idle
        do_start(16'h0010);
        tick(1);
        push_rec(15'h0010, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 4);
        bus_cycle(15'h0010, 8'h11, 1'b0, 1'b1, 1'b0, 1'b1);
        check("pre_ss_rec_count", 32'(rec_count), 32'd1);
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        @(negedge clk);
        check("ss_busy", 32'(busy), 32'd0);
        check("ss_rec_count", 32'(rec_count), 32'd0);
        tick(1);
        bus_cycle(15'h0666, 8'h66, 1'b0, 1'b1, 1'b0, 1'b1);
        check("ss_idle_rec_count", 32'(rec_count), 32'd0);

        tick(2);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
